// File: rtl/sipo_rr_sched.sv
// Round-robin scheduler sharing one serial-to-parallel deserializer among NUM_CH
// strobed serial sources; completed words leave on a valid/ready port tagged by channel.
module sipo_rr_sched #(
  parameter int NUM_CH     = 4,
  parameter int WORD_BW    = 8,
  parameter int SHIFT_LEFT = 1,
  localparam int CH_BW     = $clog2(NUM_CH)
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic [NUM_CH-1:0]   req_i,
  input  logic [NUM_CH-1:0]   serial_data_i,
  input  logic [NUM_CH-1:0]   bit_valid_i,
  output logic [NUM_CH-1:0]   gnt_o,
  output logic [WORD_BW-1:0]  word_o,
  output logic [CH_BW-1:0]    ch_id_o,
  output logic                word_valid_o,
  input  logic                word_ready_i,
  output logic                abort_o,
  output logic                busy_o
);

  localparam int CNT_BW = $clog2(WORD_BW) + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_OUT} state_e;

  state_e              state_q, state_d;
  logic [NUM_CH-1:0]   gnt_q, gnt_d;
  logic [CH_BW-1:0]    ch_id_q, ch_id_d;
  logic [CH_BW-1:0]    last_q, last_d;
  logic [WORD_BW-1:0]  word_q, word_d;
  logic [CNT_BW-1:0]   cnt_q, cnt_d;
  logic                valid_q, valid_d;
  logic                abort_q, abort_d;

  logic [CH_BW-1:0]    pick;
  logic                pick_found;
  logic                sel_bit;
  logic                sel_strobe;
  logic                sel_req;
  logic [WORD_BW-1:0]  word_shift;

  // Scan from the farthest to the nearest candidate after last_q so the nearest one wins.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    for (int k = NUM_CH; k >= 1; k--) begin
      if (req_i[(int'(last_q) + k) % NUM_CH]) begin
        pick       = CH_BW'((int'(last_q) + k) % NUM_CH);
        pick_found = 1'b1;
      end
    end
  end

  assign sel_bit    = serial_data_i[ch_id_q];
  assign sel_strobe = bit_valid_i[ch_id_q];
  assign sel_req    = req_i[ch_id_q];

  if (SHIFT_LEFT != 0) begin : g_shift_left
    assign word_shift = {word_q[WORD_BW-2:0], sel_bit};
  end else begin : g_shift_right
    assign word_shift = {sel_bit, word_q[WORD_BW-1:1]};
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ch_id_d = ch_id_q;
    last_d  = last_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    abort_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          gnt_d   = NUM_CH'(1) << pick;
          ch_id_d = pick;
          last_d  = pick;
          cnt_d   = '0;
          word_d  = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // A strobed bit always wins over a dropped request on the same cycle.
        if (sel_strobe) begin
          word_d = word_shift;
          cnt_d  = cnt_q + CNT_BW'(1);
          if (cnt_q == CNT_BW'(WORD_BW - 1)) begin
            gnt_d   = '0;
            valid_d = 1'b1;
            state_d = ST_OUT;
          end
        end else if (!sel_req) begin
          gnt_d   = '0;
          abort_d = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      ST_OUT: begin
        if (word_ready_i) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      ch_id_q <= '0;
      last_q  <= CH_BW'(NUM_CH - 1);
      word_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ch_id_q <= ch_id_d;
      last_q  <= last_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      abort_q <= abort_d;
    end
  end

  assign gnt_o        = gnt_q;
  assign word_o       = word_q;
  assign ch_id_o      = ch_id_q;
  assign word_valid_o = valid_q;
  assign abort_o      = abort_q;
  assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sipo_rr_sched.sv
// Scoreboard bench: one stimulus agent predicts grants/aborts/words at transaction level,
// a separate monitor pops expected words on each output handshake.
`timescale 1ns/1ps
module tb_sipo_rr_sched;
  localparam int N = 4;
  localparam int W = 8;

  logic         clk_i = 1'b0;
  logic         rst_n;
  logic [N-1:0] req, sdat, bval;
  logic         ready;
  logic [N-1:0] gnt_a, gnt_b;
  logic [W-1:0] word_a, word_b;
  logic [1:0]   ch_a, ch_b;
  logic         valid_a, valid_b, abort_a, abort_b, busy_a, busy_b;

  always #5 clk_i = ~clk_i;

  sipo_rr_sched #(.NUM_CH(N), .WORD_BW(W), .SHIFT_LEFT(1)) u_dut_l (
    .clk_i(clk_i), .reset_n_i(rst_n), .req_i(req), .serial_data_i(sdat),
    .bit_valid_i(bval), .gnt_o(gnt_a), .word_o(word_a), .ch_id_o(ch_a),
    .word_valid_o(valid_a), .word_ready_i(ready), .abort_o(abort_a), .busy_o(busy_a));

  sipo_rr_sched #(.NUM_CH(N), .WORD_BW(W), .SHIFT_LEFT(0)) u_dut_r (
    .clk_i(clk_i), .reset_n_i(rst_n), .req_i(req), .serial_data_i(sdat),
    .bit_valid_i(bval), .gnt_o(gnt_b), .word_o(word_b), .ch_id_o(ch_b),
    .word_valid_o(valid_b), .word_ready_i(ready), .abort_o(abort_b), .busy_o(busy_b));

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;
  int nxfer = 0;

  logic [W-1:0] wq [N][$];
  logic [W-1:0] sb_l[$];
  logic [W-1:0] sb_r[$];
  int           sb_ch[$];

  // transaction-level view of the scheduler
  bit idle_m, xfer_m, out_m, abort_m, dropped;
  int cur, last_m, bits, out_cnt;
  bit ab_plan, ab_late;
  int ab_at;
  bit dense;
  int abort_mode, force_at, ready_delay;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++)
      if (r[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  // First transmitted bit lands in the LSB when bits shift right.
  function automatic logic [W-1:0] rev(input logic [W-1:0] w);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) r[i] = w[W-1-i];
    return r;
  endfunction

  function automatic bit all_empty();
    for (int c = 0; c < N; c++)
      if (wq[c].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    idle_m = 1; xfer_m = 0; out_m = 0; abort_m = 0; dropped = 0;
    cur = 0; last_m = N - 1; bits = 0; out_cnt = 0;
    ab_plan = 0; ab_late = 0; ab_at = 0;
    for (int c = 0; c < N; c++) wq[c].delete();
    sb_l.delete(); sb_r.delete(); sb_ch.delete();
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_gnt"},   32'(gnt_a) | 32'(gnt_b), 32'd0);
    chk({tag, "_valid"}, 32'(valid_a) | 32'(valid_b), 32'd0);
    chk({tag, "_busy"},  32'(busy_a) | 32'(busy_b), 32'd0);
    chk({tag, "_abort"}, 32'(abort_a) | 32'(abort_b), 32'd0);
    chk({tag, "_word"},  32'(word_a) | 32'(word_b), 32'd0);
    chk({tag, "_ch"},    32'(ch_a) | 32'(ch_b), 32'd0);
  endtask

  task automatic cycle();
    bit n_idle, n_xfer, n_out;
    int p;
    logic [W-1:0] w;
    @(posedge clk_i); #1; cyc++;
    chk("gnt_l",   32'(gnt_a), xfer_m ? (32'd1 << cur) : 32'd0);
    chk("gnt_r",   32'(gnt_b), xfer_m ? (32'd1 << cur) : 32'd0);
    chk("valid_l", 32'(valid_a), 32'(out_m));
    chk("valid_r", 32'(valid_b), 32'(out_m));
    chk("busy",    32'(busy_a), 32'(!idle_m));
    chk("abort",   32'(abort_a), 32'(abort_m));
    n_idle = idle_m; n_xfer = xfer_m; n_out = out_m; abort_m = 1'b0;
    sdat = N'($urandom);
    bval = dense ? '0 : N'($urandom);
    for (int c = 0; c < N; c++)
      if (!req[c] && wq[c].size() != 0 && !(xfer_m && c == cur) &&
          (dense || $urandom_range(0, 2) == 0))
        req[c] = 1'b1;
    if (out_m) begin
      ready = (ready_delay < 0) ? 1'($urandom) : (out_cnt >= ready_delay);
      out_cnt++;
      if (ready) begin n_out = 0; n_idle = 1; end
    end else begin
      ready = 1'($urandom);
      out_cnt = 0;
    end
    if (xfer_m) begin
      w = wq[cur][0];
      if (dropped || (ab_plan && !ab_late && bits == ab_at)) begin
        bval[cur] = 1'b0;
        req[cur]  = 1'b0;
        void'(wq[cur].pop_front());
        n_xfer = 0; n_idle = 1; abort_m = 1; dropped = 0;
      end else if ((ab_plan && bits == ab_at) || dense || $urandom_range(0, 3) != 0) begin
        bval[cur] = 1'b1;
        sdat[cur] = w[W-1-bits];
        if (ab_plan && bits == ab_at) req[cur] = 1'b0;
        bits++;
        if (bits == W) begin
          sb_l.push_back(w); sb_r.push_back(rev(w)); sb_ch.push_back(cur);
          void'(wq[cur].pop_front());
          if (wq[cur].size() == 0) req[cur] = 1'b0;
          n_xfer = 0; n_out = 1;
        end else if (!req[cur]) begin
          dropped = 1;
        end
      end else begin
        bval[cur] = 1'b0;
      end
    end
    if (idle_m) begin
      p = rr_pick(req, last_m);
      if (p >= 0) begin
        n_idle = 0; n_xfer = 1; cur = p; last_m = p; bits = 0; dropped = 0;
        ab_plan = (abort_mode == 2) || (abort_mode == 0 && $urandom_range(0, 4) == 0);
        ab_late = (abort_mode == 0) && 1'($urandom);
        ab_at   = (abort_mode == 2) ? force_at : $urandom_range(0, W - 1);
      end
    end
    idle_m = n_idle; xfer_m = n_xfer; out_m = n_out;
  endtask

  task automatic run_phase(input int budget, input int stop_bits);
    int n;
    n = 0;
    forever begin
      cycle();
      n++;
      if (stop_bits >= 0 && xfer_m && bits == stop_bits) break;
      if (!xfer_m && !out_m && !abort_m && all_empty()) break;
      if (n >= budget) begin
        nchk++; nerr++;
        $display("FAIL phase_timeout: got %0d cycles without completion, required at most %0d", n, budget);
        break;
      end
    end
  endtask

  initial begin : monitor
    logic [W-1:0] prev_w, el, er;
    logic [1:0]   prev_c;
    bit           prev_hold;
    int           ec;
    prev_hold = 0; prev_w = '0; prev_c = '0;
    forever begin
      @(negedge clk_i);
      if (!rst_n) begin
        prev_hold = 0;
      end else begin
        if (prev_hold) begin
          chk("hold_word", 32'(word_a), 32'(prev_w));
          chk("hold_ch",   32'(ch_a), 32'(prev_c));
        end
        if (valid_a && ready) begin
          if (sb_l.size() == 0) begin
            nchk++; nerr++;
            $display("FAIL sb_underflow: got word %h ch %0d, required no word", word_a, ch_a);
          end else begin
            el = sb_l.pop_front(); er = sb_r.pop_front(); ec = sb_ch.pop_front();
            chk("word_l", 32'(word_a), 32'(el));
            chk("word_r", 32'(word_b), 32'(er));
            chk("ch_id_l", 32'(ch_a), 32'(ec));
            chk("ch_id_r", 32'(ch_b), 32'(ec));
            nxfer++;
            $display("xfer %0d: ch=%0d word_l=%h word_r=%h", nxfer, ch_a, word_a, word_b);
          end
        end
        prev_hold = valid_a && !ready;
        prev_w = word_a;
        prev_c = ch_a;
      end
    end
  end

  initial begin
    rst_n = 1'b0; req = '0; sdat = '0; bval = '0; ready = 1'b0;
    model_reset();
    dense = 1; abort_mode = 1; force_at = 0; ready_delay = 0;
    repeat (2) @(posedge clk_i);
    #1 chk_zero_outputs("reset");
    #2 rst_n = 1'b1;

    // all channels requesting, each sending its own index
    for (int c = 0; c < N; c++) wq[c].push_back(W'(c));
    wq[0].push_back(8'h00);
    run_phase(300, -1);

    // ch2 alone: A5 (palindrome) then C0 / 03
    wq[2].push_back(8'hA5);
    wq[2].push_back(8'hC0);
    run_phase(200, -1);

    // pending word under 5 cycles of backpressure while ch1 waits
    ready_delay = 5;
    wq[0].push_back(8'h3C);
    wq[1].push_back(8'h5A);
    run_phase(200, -1);

    // ch3 aborts after 3 bits, then everyone requests: ch0 must win
    ready_delay = 0; abort_mode = 2; force_at = 3;
    wq[3].push_back(8'hFF);
    run_phase(100, -1);
    abort_mode = 1;
    for (int c = 0; c < N; c++) wq[c].push_back(W'($urandom));
    run_phase(300, -1);

    // randomized traffic with gaps, aborts and random backpressure
    dense = 0; abort_mode = 0; ready_delay = -1;
    for (int c = 0; c < N; c++) begin
      int nw;
      nw = $urandom_range(3, 6);
      for (int k = 0; k < nw; k++) wq[c].push_back(W'($urandom));
    end
    run_phase(5000, -1);
    @(negedge clk_i); #1;
    chk("sb_empty", 32'(sb_l.size()), 32'd0);

    // reset mid-shift after 4 bits, then a clean restart
    dense = 1; abort_mode = 1; ready_delay = 0;
    wq[2].push_back(8'h96);
    run_phase(50, 4);
    @(posedge clk_i);
    #3 rst_n = 1'b0;
    #1 chk_zero_outputs("async_rst");
    req = '0; bval = '0; sdat = '0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #3 rst_n = 1'b1;
    for (int c = 0; c < N; c++) wq[c].push_back(W'($urandom));
    run_phase(300, -1);
    @(negedge clk_i); #1;
    chk("sb_empty_end", 32'(sb_l.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
